axi_master_bridge: RTL and testbench

//  AXI3/4-style master: converts one CPU-side memory request (IFU/LSU) into one AXI burst.
//  It is the initiator facing sim_sram-style 64-bit responders; one transaction is outstanding at a time.

---
 rtl/axi_pkg.sv | 20 ++
 rtl/axi_master_bridge.sv | 175 +++++++++++++++++
 tb/tb_axi_master_bridge.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and bridge FSM states for the CPU-side AXI master bridge.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_RD   = 3'd2,
    ST_AW   = 3'd3,
    ST_WD   = 3'd4,
    ST_BR   = 3'd5
  } bridge_state_t;

endpackage

// File: rtl/axi_master_bridge.sv
// Single-outstanding AXI master: turns one CPU request into one INCR burst,
// streaming read beats to rd_* and pulling write beats from wd_*.
module axi_master_bridge
  import axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd0,
  parameter int         DW     = 64,
  parameter int         AW     = 32
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [7:0]      req_len,
  input  logic [2:0]      req_size,
  input  logic [3:0]      req_id,
  input  logic            wd_valid,
  output logic            wd_ready,
  input  logic [DW-1:0]   wd_data,
  input  logic [DW/8-1:0] wd_strb,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [DW-1:0]   rd_data,
  output logic            rd_last,
  output logic [1:0]      rd_resp,
  output logic            wr_done,
  output logic [1:0]      wr_resp,
  output logic            err,
  output logic [AW-1:0]   araddr,
  output logic [3:0]      arid,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [1:0]      arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [3:0]      rid,
  input  logic [DW-1:0]   rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [AW-1:0]   awaddr,
  output logic [3:0]      awid,
  output logic [7:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  output logic [3:0]      wid,
  output logic [DW-1:0]   wdata,
  output logic [DW/8-1:0] wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [3:0]      bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);

  bridge_state_t state;
  logic [7:0]    beat_cnt;
  logic [AW-1:0] addr_r;
  logic [7:0]    len_r;
  logic [2:0]    size_r;
  logic [3:0]    id_r;
  logic [1:0]    wr_resp_r;
  logic          err_r;
  logic          wr_done_r;

  logic accept, r_hs, w_hs, b_hs, at_last;

  assign accept  = (state == ST_IDLE) && req_valid;
  assign r_hs    = (state == ST_RD) && rvalid && rd_ready;
  assign w_hs    = (state == ST_WD) && wd_valid && wready;
  assign b_hs    = (state == ST_BR) && bvalid;
  assign at_last = (beat_cnt == len_r);

  // Control: FSM, beat counter, sticky error and completion pulse
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      beat_cnt  <= 8'd0;
      err_r     <= 1'b0;
      wr_done_r <= 1'b0;
      id_r      <= AXI_ID;
    end else begin
      wr_done_r <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          state    <= req_write ? ST_AW : ST_AR;
          beat_cnt <= 8'd0;
          id_r     <= req_id;
        end
        ST_AR: if (arready) state <= ST_RD;
        ST_RD: if (r_hs) begin
          beat_cnt <= beat_cnt + 8'd1;
          // A misplaced or missing rlast is flagged but the burst still ends on rlast
          if ((rlast != at_last) || (rid != id_r)) err_r <= 1'b1;
          if (rlast) state <= ST_IDLE;
        end
        ST_AW: if (awready) state <= ST_WD;
        ST_WD: if (w_hs) begin
          beat_cnt <= beat_cnt + 8'd1;
          if (at_last) state <= ST_BR;
        end
        ST_BR: if (b_hs) begin
          wr_done_r <= 1'b1;
          if (bid != id_r) err_r <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Data: request fields and B response, no reset needed
  always_ff @(posedge aclk) begin
    if (accept) begin
      addr_r <= req_addr;
      len_r  <= req_len;
      size_r <= req_size;
    end
    if (b_hs) wr_resp_r <= bresp;
  end

  assign req_ready = (state == ST_IDLE);
  assign wr_done   = wr_done_r;
  assign wr_resp   = wr_resp_r;
  assign err       = err_r;

  assign arvalid = (state == ST_AR);
  assign araddr  = addr_r;
  assign arid    = id_r;
  assign arlen   = len_r;
  assign arsize  = size_r;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign rready   = (state == ST_RD) && rd_ready;
  assign rd_valid = (state == ST_RD) && rvalid;
  assign rd_data  = rdata;
  assign rd_last  = rlast;
  assign rd_resp  = rresp;

  assign awvalid = (state == ST_AW);
  assign awaddr  = addr_r;
  assign awid    = id_r;
  assign awlen   = len_r;
  assign awsize  = size_r;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wvalid   = (state == ST_WD) && wd_valid;
  assign wd_ready = (state == ST_WD) && wready;
  assign wdata    = wd_data;
  assign wstrb    = wd_strb;
  assign wlast    = at_last;
  assign wid      = id_r;

  assign bready = (state == ST_BR);

endmodule

// File: tb/tb_axi_master_bridge.sv
// Bench for axi_master_bridge: directed vector table, reset/sticky corner sequences,
// then randomized bursts checked against a transaction-level expectation model.
module tb_axi_master_bridge;
  import axi_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [3:0]  req_id;
  logic        wd_valid, wd_ready;
  logic [63:0] wd_data;
  logic [7:0]  wd_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [63:0] rd_data;
  logic [1:0]  rd_resp;
  logic        wr_done, err;
  logic [1:0]  wr_resp;
  logic [31:0] araddr, awaddr;
  logic [3:0]  arid, awid, arcache, awcache, wid, rid, bid;
  logic [7:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, awvalid, awready;
  logic [63:0] rdata, wdata;
  logic        rlast, rvalid, rready, wlast, wvalid, wready, bvalid, bready;

  always #5 aclk = ~aclk;

  axi_master_bridge dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_size(req_size), .req_id(req_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rd_resp(rd_resp), .wr_done(wr_done), .wr_resp(wr_resp), .err(err),
    .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_chk = 0;
  int n_err = 0;
  bit model_err;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  id;
    int          rlast_at;
    logic [3:0]  rsp_id;
    logic [1:0]  resp;
    int          stall;
    bit          tog;
    logic [63:0] data;
    logic [7:0]  s0;
    logic [7:0]  s1;
    bit          exp_err;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_write = 0; req_addr = 0; req_len = 0; req_size = 0; req_id = 0;
    wd_valid = 0; wd_data = 0; wd_strb = 0; rd_ready = 0;
    arready = 0; awready = 0; wready = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    bid = 0; bresp = 0; bvalid = 0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    idle_inputs();
    repeat (2) step();
    aresetn = 1'b1;
    model_err = 1'b0;
    step();
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [3:0] id);
    req_write = wr; req_addr = addr; req_len = len; req_size = size; req_id = id;
    req_valid = 1'b1;
    #1 check("req_ready_idle", req_ready, 1'b1);
    step();
    // scramble the request bus so only latched values can reach AR/AW
    req_valid = 1'b0;
    req_write = 1'($urandom); req_addr = $urandom; req_len = 8'($urandom);
    req_size = 3'($urandom); req_id = 4'($urandom);
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [3:0] id, input int rlast_at, input logic [3:0] rsp_id,
                          input int stall, input bit tog);
    bit          hs;
    logic [63:0] d;
    logic [1:0]  rs;
    issue(1'b0, addr, len, size, id);
    rd_ready = 1'b1; rvalid = 1'b1;
    #1;
    check("arvalid", arvalid, 1'b1);
    check("awvalid_in_rd", awvalid, 1'b0);
    check("rready_in_ar", rready, 1'b0);
    check("ar_fields", {araddr, arid, arlen, arsize}, {addr, id, len, size});
    check("ar_consts", {arburst, arlock, arcache, arprot}, {AXI_BURST_INCR, 9'd0});
    rvalid = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      step();
      check("arvalid_hold", arvalid, 1'b1);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    if (rlast_at != int'(len) || rsp_id != id) model_err = 1'b1;
    for (int k = 0; k <= rlast_at; k++) begin
      repeat (stall) begin
        rvalid = 1'b0; rd_ready = 1'($urandom);
        step();
      end
      d = {$urandom, $urandom};
      rs = 2'($urandom);
      rvalid = 1'b1; rdata = d; rresp = rs; rid = rsp_id; rlast = (k == rlast_at);
      hs = 1'b0;
      for (int c = 0; c < 40 && !hs; c++) begin
        rd_ready = tog ? (c % 2 == 1) : 1'b1;
        #1;
        check("rd_valid", rd_valid, 1'b1);
        check("rd_beat", {rd_data, rd_last, rd_resp}, {d, (k == rlast_at), rs});
        check("rready_follow", rready, rd_ready);
        hs = rd_ready;
        step();
      end
      if (!hs) check("r_handshake_timeout", 1'b0, 1'b1);
    end
    rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0;
    check("rd_back_idle", req_ready, 1'b1);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [3:0] id, input logic [3:0] rsp_id, input logic [1:0] rsp,
                           input logic [63:0] base, input logic [7:0] s0, input logic [7:0] s1,
                           input bit rnd);
    bit          hs;
    logic [63:0] d;
    logic [7:0]  s;
    issue(1'b1, addr, len, size, id);
    wd_valid = 1'b1; wd_data = base; wready = 1'b1;
    #1;
    check("awvalid", awvalid, 1'b1);
    check("arvalid_in_wr", arvalid, 1'b0);
    check("no_w_before_aw", {wvalid, wd_ready}, 2'b00);
    check("aw_fields", {awaddr, awid, awlen, awsize}, {addr, id, len, size});
    check("aw_consts", {awburst, awlock, awcache, awprot}, {AXI_BURST_INCR, 9'd0});
    wd_valid = 1'b0; wready = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      step();
      check("awvalid_hold", awvalid, 1'b1);
    end
    awready = 1'b1;
    step();
    awready = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      d = rnd ? {$urandom, $urandom} : base;
      s = rnd ? 8'($urandom) : ((k == 0) ? s0 : s1);
      repeat ($urandom_range(0, 1)) begin
        wd_valid = 1'b0;
        #1 check("wvalid_gap", wvalid, 1'b0);
        step();
      end
      wd_valid = 1'b1; wd_data = d; wd_strb = s;
      hs = 1'b0;
      for (int c = 0; c < 40 && !hs; c++) begin
        wready = (c >= 2) ? 1'b1 : 1'($urandom);
        #1;
        check("wvalid", wvalid, 1'b1);
        check("w_beat", {wdata, wstrb, wlast, wid}, {d, s, (k == int'(len)), id});
        check("wd_ready_follow", wd_ready, wready);
        hs = wready;
        step();
      end
      if (!hs) check("w_handshake_timeout", 1'b0, 1'b1);
    end
    wd_valid = 1'b0; wready = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      check("bready_wait", {bready, wr_done}, 2'b10);
      step();
    end
    check("bready", bready, 1'b1);
    bvalid = 1'b1; bid = rsp_id; bresp = rsp;
    step();
    bvalid = 1'b0;
    if (rsp_id != id) model_err = 1'b1;
    check("wr_done_pulse", wr_done, 1'b1);
    check("wr_resp", wr_resp, rsp);
    check("wr_back_idle", {req_ready, bready}, 2'b10);
    step();
    check("wr_done_one_cycle", wr_done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        wr addr          len  sz id rl  rid rsp st tg data                     s0     s1     err
    tbl[0] = '{0, 32'h8000_0000, 8'd0, 3, 3, 0, 3, 0, 0, 0, 64'h0,                   8'h00, 8'h00, 0};
    tbl[1] = '{0, 32'h0000_1000, 8'd3, 3, 1, 3, 1, 0, 2, 1, 64'h0,                   8'h00, 8'h00, 0};
    tbl[2] = '{1, 32'h0000_2000, 8'd1, 3, 4, 0, 4, 0, 0, 0, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 8'h0F, 0};
    tbl[3] = '{0, 32'h0000_3000, 8'd3, 3, 6, 2, 6, 0, 0, 0, 64'h0,                   8'h00, 8'h00, 1};
    tbl[4] = '{1, 32'h0000_4000, 8'd0, 2, 2, 0, 5, 2, 0, 0, 64'h1234_5678_9ABC_DEF0, 8'h3C, 8'h00, 1};
    tbl[5] = '{0, 32'h0000_5000, 8'd2, 1, 7, 2, 8, 0, 1, 0, 64'h0,                   8'h00, 8'h00, 1};

    aresetn = 1'b0;
    do_reset();
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_valids", {arvalid, awvalid, wvalid, bready, rready}, 5'd0);
    check("rst_flags", {wr_done, err}, 2'b00);

    foreach (tbl[i]) begin
      do_reset();
      if (tbl[i].wr)
        run_write(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].id, tbl[i].rsp_id, tbl[i].resp,
                  tbl[i].data, tbl[i].s0, tbl[i].s1, 1'b0);
      else
        run_read(tbl[i].addr, tbl[i].len, tbl[i].size, tbl[i].id, tbl[i].rlast_at,
                 tbl[i].rsp_id, tbl[i].stall, tbl[i].tog);
      check($sformatf("tbl%0d_err", i), err, tbl[i].exp_err);
    end

    // err stays set across a following clean read
    do_reset();
    run_read(32'h600, 8'd1, 3'd3, 4'd9, 0, 4'd9, 0, 0);
    check("err_set", err, 1'b1);
    run_read(32'h700, 8'd1, 3'd3, 4'd9, 1, 4'd9, 1, 0);
    check("err_sticky", err, 1'b1);

    // reset during the second W beat of a 4-beat write
    do_reset();
    issue(1'b1, 32'h8000, 8'd3, 3'd3, 4'd2);
    awready = 1'b1;
    step();
    awready = 1'b0;
    wd_valid = 1'b1; wready = 1'b1; wd_data = 64'h1; wd_strb = 8'hFF;
    step();
    wd_data = 64'h2;
    #1 check("mid_beat1_wvalid", wvalid, 1'b1);
    aresetn = 1'b0;
    step();
    check("mid_rst_valids", {wvalid, awvalid, arvalid, bready}, 4'd0);
    check("mid_rst_req_ready", req_ready, 1'b1);
    check("mid_rst_no_done", wr_done, 1'b0);
    aresetn = 1'b1;
    wd_valid = 1'b0; wready = 1'b0;
    bvalid = 1'b1; bid = 4'd2;
    repeat (3) begin
      step();
      check("mid_rst_b_ignored", {wr_done, bready}, 2'b00);
    end
    bvalid = 1'b0;

    // randomized back-to-back traffic
    do_reset();
    for (int t = 0; t < 30; t++) begin
      bit          wr;
      logic [7:0]  len;
      logic [3:0]  id, rsp_id;
      int          rl;
      wr  = 1'($urandom);
      len = 8'($urandom_range(0, 7));
      id  = 4'($urandom);
      rsp_id = ($urandom_range(0, 9) == 0) ? id + 4'd1 : id;
      rl = int'(len);
      if ($urandom_range(0, 9) == 0)
        rl = (len > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, int'(len) - 1) : int'(len) + 1;
      if (wr)
        run_write($urandom, len, 3'($urandom_range(0, 3)), id, rsp_id, 2'($urandom),
                  64'h0, 8'h00, 8'h00, 1'b1);
      else
        run_read($urandom, len, 3'($urandom_range(0, 3)), id, rl, rsp_id,
                 $urandom_range(0, 2), 1'($urandom));
      check($sformatf("rand%0d_err", t), err, model_err);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
